// File: rtl/pc_sequencer_if.sv
// Fetch-stage redirect controls in, PC / EPC / return-address-stack status out.
interface pc_sequencer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int RAS_DEPTH  = 4
);
   logic                          pc_enable;
   logic                          jump;
   logic [25:0]                   jea;
   logic                          branch;
   logic                          zero;
   logic                          is_nop;
   logic [ADDR_WIDTH-1:0]         imm_sign_extend;
   logic                          jump_register;
   logic [ADDR_WIDTH-1:0]         rs_data;
   logic                          link;
   logic                          ret;
   logic                          exception;
   logic                          eret;
   logic [ADDR_WIDTH-1:0]         pc;
   logic [ADDR_WIDTH-1:0]         epc;
   logic [ADDR_WIDTH-1:0]         ras_top;
   logic [$clog2(RAS_DEPTH):0]    ras_count;
   logic                          ras_mispredict;
   logic                          addr_misalign;

   modport master (
      output pc_enable, jump, jea, branch, zero, is_nop, imm_sign_extend,
             jump_register, rs_data, link, ret, exception, eret,
      input  pc, epc, ras_top, ras_count, ras_mispredict, addr_misalign
   );

   modport slave (
      input  pc_enable, jump, jea, branch, zero, is_nop, imm_sign_extend,
             jump_register, rs_data, link, ret, exception, eret,
      output pc, epc, ras_top, ras_count, ras_mispredict, addr_misalign
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC select, exception/EPC handling
// and a circular return-address stack that checks `jr $ra` targets.
module pc_sequencer #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(32'h0000_0180),
   parameter int                    RAS_DEPTH    = 4
) (
   input logic          clk,
   input logic          rst,
   pc_sequencer_if.slave bus
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] pc_r, epc_r;
   logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]         ptr;
   logic [CW-1:0]         count;
   logic                  mispredict_r, misalign_r;

   logic [ADDR_WIDTH-1:0] pc4, jaddr, baddr, top_val;
   logic                  btaken, jr_misalign, active, redirect_ok;
   logic                  sel_jump, sel_jr, sel_mis, do_push, do_pop, empty;
   logic [PW-1:0]         top_idx, pop_ptr, ptr_nxt;
   logic [CW-1:0]         pop_cnt, cnt_nxt;
   logic                  mispredict_nxt;

   assign pc4   = pc_r + ADDR_WIDTH'(4);
   assign baddr = pc4 + {bus.imm_sign_extend[ADDR_WIDTH-3:0], 2'b00};

   generate
      if (ADDR_WIDTH == 28) begin : g_jaddr_narrow
         assign jaddr = {bus.jea, 2'b00};
      end else begin : g_jaddr_wide
         assign jaddr = {pc4[ADDR_WIDTH-1:28], bus.jea, 2'b00};
      end
   endgenerate

   always_comb begin
      btaken      = bus.branch & bus.zero & ~bus.is_nop;
      jr_misalign = bus.rs_data[1:0] != 2'b00;
      active      = ~bus.exception & bus.pc_enable;
      // Only the jump and aligned jump-register cases may touch the RAS.
      redirect_ok = active & ~bus.eret & ~bus.jump & ~btaken & bus.jump_register;
      sel_jump    = active & ~bus.eret & bus.jump;
      sel_jr      = redirect_ok & ~jr_misalign;
      sel_mis     = redirect_ok & jr_misalign;
      do_push     = bus.link & (sel_jump | sel_jr);
      do_pop      = bus.ret & sel_jr;

      empty   = count == '0;
      top_idx = ptr - PW'(1);
      top_val = empty ? '0 : ras_mem[top_idx];

      // Pop first, then push into the freed slot.
      pop_ptr = (do_pop & ~empty) ? top_idx : ptr;
      pop_cnt = (do_pop & ~empty) ? count - CW'(1) : count;
      ptr_nxt = do_push ? pop_ptr + PW'(1) : pop_ptr;
      cnt_nxt = pop_cnt;
      if (do_push && pop_cnt != CW'(RAS_DEPTH)) cnt_nxt = pop_cnt + CW'(1);
      mispredict_nxt = do_pop & (empty | (top_val != bus.rs_data));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r         <= RESET_VECTOR;
         epc_r        <= '0;
         ptr          <= '0;
         count        <= '0;
         mispredict_r <= 1'b0;
         misalign_r   <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else begin
         mispredict_r <= mispredict_nxt;
         misalign_r   <= sel_mis;
         ptr          <= ptr_nxt;
         count        <= cnt_nxt;
         if (do_push) ras_mem[pop_ptr] <= pc4;

         if (bus.exception) begin
            epc_r <= pc_r;
            pc_r  <= EXC_VECTOR;
         end else if (bus.pc_enable) begin
            if (bus.eret)                pc_r <= epc_r;
            else if (bus.jump)           pc_r <= jaddr;
            else if (btaken)             pc_r <= baddr;
            else if (sel_mis) begin
               epc_r <= pc_r;
               pc_r  <= EXC_VECTOR;
            end
            else if (bus.jump_register)  pc_r <= bus.rs_data;
            else                         pc_r <= pc4;
         end
      end
   end

   assign bus.pc             = pc_r;
   assign bus.epc            = epc_r;
   assign bus.ras_top        = top_val;
   assign bus.ras_count      = count;
   assign bus.ras_mispredict = mispredict_r;
   assign bus.addr_misalign  = misalign_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, priority, exceptions, misalign, RAS.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_WIDTH(32), .RAS_DEPTH(4)) bus ();

   pc_sequencer #(
      .ADDR_WIDTH  (32),
      .RESET_VECTOR(32'h100),
      .EXC_VECTOR  (32'h180),
      .RAS_DEPTH   (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pc_enable       = 1'b1;
      bus.jump            = 1'b0;
      bus.jea             = '0;
      bus.branch          = 1'b0;
      bus.zero            = 1'b0;
      bus.is_nop          = 1'b0;
      bus.imm_sign_extend = '0;
      bus.jump_register   = 1'b0;
      bus.rs_data         = '0;
      bus.link            = 1'b0;
      bus.ret             = 1'b0;
      bus.exception       = 1'b0;
      bus.eret            = 1'b0;
   endtask

   task automatic set_pc(input logic [31:0] a);
      idle();
      bus.jump_register = 1'b1;
      bus.rs_data       = a;
      cyc();
      idle();
   endtask

   task automatic jal(input logic [25:0] target_field);
      idle();
      bus.jump = 1'b1;
      bus.link = 1'b1;
      bus.jea  = target_field;
      cyc();
      idle();
   endtask

   task automatic jr_ra(input logic [31:0] a, input logic lnk);
      idle();
      bus.jump_register = 1'b1;
      bus.ret           = 1'b1;
      bus.link          = lnk;
      bus.rs_data       = a;
      cyc();
      idle();
   endtask

   initial begin
      // Reset overrides a simultaneous exception.
      idle();
      bus.pc_enable = 1'b0;
      bus.exception = 1'b1;
      rst = 1'b1;
      cyc();
      cyc();
      check("rst_pc", bus.pc, 32'h100);
      check("rst_epc", bus.epc, 0);
      check("rst_cnt", bus.ras_count, 0);
      check("rst_top", bus.ras_top, 0);
      check("rst_mp", bus.ras_mispredict, 0);
      check("rst_mis", bus.addr_misalign, 0);

      rst = 1'b0;
      idle();
      cyc(); check("seq1", bus.pc, 32'h104);
      cyc(); check("seq2", bus.pc, 32'h108);
      cyc(); check("seq3", bus.pc, 32'h10C);

      // Priority: jump beats branch and jump_register.
      set_pc(32'h200);
      check("setpc", bus.pc, 32'h200);
      bus.jump = 1'b1; bus.jea = 26'h40;
      bus.branch = 1'b1; bus.zero = 1'b1;
      bus.jump_register = 1'b1; bus.rs_data = 32'h300;
      cyc(); idle();
      check("prio_jump", bus.pc, 32'h100);
      bus.branch = 1'b1; bus.zero = 1'b1; bus.is_nop = 1'b1;
      cyc();
      check("br_nop", bus.pc, 32'h104);
      bus.is_nop = 1'b0; bus.imm_sign_extend = 32'hFFFF_FFFE;
      cyc(); idle();
      check("br_back", bus.pc, 32'h100);
      bus.branch = 1'b1; bus.zero = 1'b0; bus.imm_sign_extend = 32'h10;
      cyc(); idle();
      check("br_nz", bus.pc, 32'h104);

      // Exception during stall, stall hold, then eret.
      set_pc(32'h40);
      bus.pc_enable = 1'b0; bus.exception = 1'b1;
      cyc(); idle();
      check("exc_pc", bus.pc, 32'h180);
      check("exc_epc", bus.epc, 32'h40);
      cyc(); cyc();
      check("exc_run", bus.pc, 32'h188);
      bus.pc_enable = 1'b0; bus.jump = 1'b1; bus.jea = 26'h10;
      cyc(); idle();
      check("stall_hold", bus.pc, 32'h188);
      bus.eret = 1'b1;
      cyc(); idle();
      check("eret_pc", bus.pc, 32'h40);

      // Misaligned jump-register; link must not push.
      set_pc(32'h300);
      bus.jump_register = 1'b1; bus.link = 1'b1; bus.rs_data = 32'h402;
      cyc(); idle();
      check("mis_pc", bus.pc, 32'h180);
      check("mis_epc", bus.epc, 32'h300);
      check("mis_pulse", bus.addr_misalign, 1);
      check("mis_cnt", bus.ras_count, 0);
      cyc();
      check("mis_clr", bus.addr_misalign, 0);

      // RAS push / pop / empty-pop / wrong target.
      set_pc(32'h10);
      jal(26'h20);
      check("jal_pc", bus.pc, 32'h80);
      check("jal_top", bus.ras_top, 32'h14);
      check("jal_cnt", bus.ras_count, 1);
      jr_ra(32'h14, 1'b0);
      check("pop_pc", bus.pc, 32'h14);
      check("pop_cnt", bus.ras_count, 0);
      check("pop_mp", bus.ras_mispredict, 0);
      jr_ra(32'h14, 1'b0);
      check("empty_mp", bus.ras_mispredict, 1);
      check("empty_cnt", bus.ras_count, 0);
      check("empty_pc", bus.pc, 32'h14);
      cyc();
      check("mp_clr", bus.ras_mispredict, 0);
      jal(26'h40);
      check("jal2_top", bus.ras_top, 32'h1C);
      jr_ra(32'h20, 1'b0);
      check("wrong_mp", bus.ras_mispredict, 1);
      check("wrong_pc", bus.pc, 32'h20);
      check("wrong_cnt", bus.ras_count, 0);

      // Overflow: five calls into a four-deep stack.
      set_pc(32'h0);
      for (int i = 0; i < 5; i++) jal((i < 4) ? 26'((i + 1) * 4) : 26'h80);
      check("ovf_pc", bus.pc, 32'h200);
      check("ovf_cnt", bus.ras_count, 4);
      check("ovf_top", bus.ras_top, 32'h44);
      bus.pc_enable = 1'b0; bus.jump = 1'b1; bus.link = 1'b1; bus.jea = 26'h10;
      cyc(); idle();
      check("stall_pc", bus.pc, 32'h200);
      check("stall_cnt", bus.ras_count, 4);
      check("stall_top", bus.ras_top, 32'h44);
      jr_ra(32'h44, 1'b0);
      check("p1_mp", bus.ras_mispredict, 0);
      check("p1_top", bus.ras_top, 32'h34);
      jr_ra(32'h34, 1'b0);
      check("p2_mp", bus.ras_mispredict, 0);
      check("p2_top", bus.ras_top, 32'h24);
      jr_ra(32'h24, 1'b0);
      check("p3_mp", bus.ras_mispredict, 0);
      check("p3_top", bus.ras_top, 32'h14);
      jr_ra(32'h14, 1'b0);
      check("p4_mp", bus.ras_mispredict, 0);
      check("p4_cnt", bus.ras_count, 0);
      check("p4_top", bus.ras_top, 0);
      jr_ra(32'h14, 1'b0);
      check("p5_mp", bus.ras_mispredict, 1);

      // Simultaneous pop and push (JALR to the predicted return).
      set_pc(32'h500);
      jal(26'h180);
      check("pp_pre", bus.ras_top, 32'h504);
      jr_ra(32'h504, 1'b1);
      check("pp_pc", bus.pc, 32'h504);
      check("pp_mp", bus.ras_mispredict, 0);
      check("pp_cnt", bus.ras_count, 1);
      check("pp_top", bus.ras_top, 32'h604);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
